// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared definitions for the data-memory bus arbiter.
//   BUS_W       : width of the data-memory address / data bus
//   HOLD_W      : width of the grant hold counter
//   arb_state_e : arbiter FSM states (ARB_IDLE = no grant, ARB_OWNED = one grant)
//   idx_width() : bits needed to hold a master index (at least 1)
package dmem_bus_arbiter_pkg;

  localparam int unsigned BUS_W  = 8;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_bus_arbiter_rr_pick.sv
// Combinational round-robin select.
//   req        : request vector
//   mask       : masters excluded from selection
//   last       : index of the most recent owner; the search starts at last+1
//   winner     : one-hot winner (zero when nothing is eligible)
//   winner_idx : binary index of the winner
//   valid      : some master was selected
module rr_pick
  import dmem_bus_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_MST = 4,
  localparam int unsigned IDX_W   = idx_width(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [NUM_MST-1:0] mask,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_MST-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  logic [NUM_MST-1:0] eligible;
  logic [IDX_W-1:0]   scan_idx;

  assign eligible = req & ~mask;

  // Visit last+1, last+2, ... wrapping modulo NUM_MST; last itself is visited
  // last of all, so the previous owner has the lowest priority.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 1; k <= NUM_MST; k++) begin
      scan_idx = IDX_W'((32'(last) + k) % NUM_MST);
      if (!valid && eligible[scan_idx]) begin
        valid      = 1'b1;
        winner_idx = scan_idx;
      end
    end
    winner[winner_idx] = valid;
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit data-memory bus.
//   clk, rst_n           : clock, asynchronous active-low reset
//   mst_req              : per-master level request
//   mst_grant            : registered per-master grant, one-hot or zero
//   mst_addr/mst_wdata   : master i bus fields in bits [8i+7:8i]
//   mst_wr/mst_rd        : per-master strobes
//   slv_addr/wr/rd/wdata : bus fields of the current owner, zero when idle
//   busy                 : a grant is active
//   hold_timeout         : one-cycle pulse after the watchdog revoked a grant
// A grant is kept while its owner requests; the watchdog revokes a grant after
// MAX_HOLD consecutive cycles (0 disables it) and masks that master until it
// drops its request.
module dmem_bus_arbiter
  import dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MST  = 4,
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_MST-1:0]         mst_req,
  output logic [NUM_MST-1:0]         mst_grant,
  input  logic [BUS_W*NUM_MST-1:0]   mst_addr,
  input  logic [NUM_MST-1:0]         mst_wr,
  input  logic [NUM_MST-1:0]         mst_rd,
  input  logic [BUS_W*NUM_MST-1:0]   mst_wdata,
  output logic [BUS_W-1:0]           slv_addr,
  output logic                       slv_wr,
  output logic                       slv_rd,
  output logic [BUS_W-1:0]           slv_wdata,
  output logic                       busy,
  output logic                       hold_timeout
);

  localparam int unsigned IDX_W = idx_width(NUM_MST);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic WDOG_EN = (MAX_HOLD != 0);

  arb_state_e          state_q, state_d;
  logic [NUM_MST-1:0]  grant_q, grant_d;
  logic [NUM_MST-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                hold_timeout_q, hold_timeout_d;

  logic [NUM_MST-1:0]  cand_req;
  logic [NUM_MST-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                owner_req;
  logic                hold_expired;

  // The current owner is excluded from candidacy, so the same pick serves the
  // idle case (grant_q is zero), a release and a watchdog revocation.
  assign cand_req = mst_req & ~grant_q;

  rr_pick #(
    .NUM_MST (NUM_MST)
  ) u_rr_pick (
    .req        (cand_req),
    .mask       (mask_q),
    .last       (last_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign owner_req    = |(mst_req & grant_q);
  assign hold_expired = WDOG_EN && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    hold_cnt_d     = hold_cnt_q;
    hold_timeout_d = 1'b0;
    // A mask bit survives only while its master keeps requesting.
    mask_d         = mask_q & mst_req;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_OWNED;
          grant_d    = pick_onehot;
          last_d     = pick_idx;
          hold_cnt_d = '0;
        end
      end
      ARB_OWNED: begin
        if (owner_req && !hold_expired) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          // Revocation only applies to an owner still requesting; a voluntary
          // release on the expiry cycle is an ordinary release.
          if (owner_req) begin
            hold_timeout_d = 1'b1;
            mask_d         = mask_d | grant_q;
          end
          hold_cnt_d = '0;
          if (pick_valid) begin
            grant_d = pick_onehot;
            last_d  = pick_idx;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      grant_q        <= '0;
      mask_q         <= '0;
      last_q         <= IDX_W'(NUM_MST - 1);
      hold_cnt_q     <= '0;
      hold_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      mask_q         <= mask_d;
      last_q         <= last_d;
      hold_cnt_q     <= hold_cnt_d;
      hold_timeout_q <= hold_timeout_d;
    end
  end

  // AND-OR merge from the registered grant: at most one term is non-zero.
  always_comb begin
    slv_addr  = '0;
    slv_wr    = 1'b0;
    slv_rd    = 1'b0;
    slv_wdata = '0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      slv_addr  = slv_addr  | (mst_addr[BUS_W*i +: BUS_W]  & {BUS_W{grant_q[i]}});
      slv_wdata = slv_wdata | (mst_wdata[BUS_W*i +: BUS_W] & {BUS_W{grant_q[i]}});
      slv_wr    = slv_wr    | (mst_wr[i] & grant_q[i]);
      slv_rd    = slv_rd    | (mst_rd[i] & grant_q[i]);
    end
  end

  assign mst_grant    = grant_q;
  assign busy         = (state_q == ARB_OWNED);
  assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
module tb_dmem_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  mst_req;
  logic [N-1:0]  mst_grant;
  logic [8*N-1:0] mst_addr;
  logic [N-1:0]  mst_wr;
  logic [N-1:0]  mst_rd;
  logic [8*N-1:0] mst_wdata;
  logic [7:0]    slv_addr;
  logic          slv_wr;
  logic          slv_rd;
  logic [7:0]    slv_wdata;
  logic          busy;
  logic          hold_timeout;

  dmem_bus_arbiter #(
    .NUM_MST  (N),
    .MAX_HOLD (MH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mst_req      (mst_req),
    .mst_grant    (mst_grant),
    .mst_addr     (mst_addr),
    .mst_wr       (mst_wr),
    .mst_rd       (mst_rd),
    .mst_wdata    (mst_wdata),
    .slv_addr     (slv_addr),
    .slv_wr       (slv_wr),
    .slv_rd       (slv_rd),
    .slv_wdata    (slv_wdata),
    .busy         (busy),
    .hold_timeout (hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         busy;
    logic         to;
    logic [7:0]   a;
    logic         wr;
    logic         rd;
    logic [7:0]   d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: owner index (-1 = none), last owner, cycles owned so far.
  int           m_owner;
  int           m_last;
  int           m_held;
  logic [N-1:0] m_mask;
  logic         m_to;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    m_mask  = '0;
    m_to    = 1'b0;
  endtask

  // One clock edge of the arbitration rules with the given requests.
  task automatic model_step(input logic [N-1:0] req);
    logic [N-1:0] old_mask;
    int nxt;
    bit rel;
    old_mask = m_mask;
    m_to     = 1'b0;
    m_mask   = m_mask & req;
    rel      = 1;
    if (m_owner >= 0 && req[m_owner] && m_held < MH) begin
      m_held++;
      rel = 0;
    end
    if (rel) begin
      if (m_owner >= 0 && req[m_owner]) begin
        m_to = 1'b1;
        m_mask[m_owner] = 1'b1;
      end
      nxt = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (nxt < 0 && req[c] && !old_mask[c] && c != m_owner) nxt = c;
      end
      m_owner = nxt;
      if (nxt >= 0) begin
        m_last = nxt;
        m_held = 1;
      end
    end
  endtask

  function automatic exp_t build_exp(input int owner, input logic to);
    exp_t e;
    e    = '0;
    e.to = to;
    if (owner >= 0) begin
      e.g[owner] = 1'b1;
      e.busy     = 1'b1;
      e.a        = mst_addr[owner*8 +: 8];
      e.wr       = mst_wr[owner];
      e.rd       = mst_rd[owner];
      e.d        = mst_wdata[owner*8 +: 8];
    end
    return e;
  endfunction

  // Drive one cycle's inputs, check the merged bus reacts with zero latency
  // to the current owner, then queue the state expected after the next edge.
  task automatic cycle(input logic [N-1:0] req, input logic [8*N-1:0] addr,
                       input logic [N-1:0] wr, input logic [N-1:0] rd,
                       input logic [8*N-1:0] wd);
    exp_t c;
    @(negedge clk);
    mst_req   = req;
    mst_addr  = addr;
    mst_wr    = wr;
    mst_rd    = rd;
    mst_wdata = wd;
    #1;
    c = build_exp(m_owner, 1'b0);
    chk("comb_addr",  32'(slv_addr),  32'(c.a));
    chk("comb_wdata", 32'(slv_wdata), 32'(c.d));
    chk("comb_wr",    32'(slv_wr),    32'(c.wr));
    chk("comb_rd",    32'(slv_rd),    32'(c.rd));
    model_step(req);
    exp_q.push_back(build_exp(m_owner, m_to));
  endtask

  task automatic rand_cycle(input logic [N-1:0] req);
    cycle(req, {$urandom, $urandom} , 4'($urandom), 4'($urandom), 32'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(mst_grant),    32'h0);
    chk({tag, "_busy"},  32'(busy),         32'h0);
    chk({tag, "_to"},    32'(hold_timeout), 32'h0);
    chk({tag, "_slv"},   {14'h0, slv_addr, slv_wdata, slv_wr, slv_rd}, 32'h0);
  endtask

  // Asynchronous reset in the middle of a cycle, away from any queued edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    model_reset();
    mst_req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare the queued expectation after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant",        32'(mst_grant),    32'(e.g));
        chk("busy",         32'(busy),         32'(e.busy));
        chk("hold_timeout", 32'(hold_timeout), 32'(e.to));
        chk("slv_addr",     32'(slv_addr),     32'(e.a));
        chk("slv_wr",       32'(slv_wr),       32'(e.wr));
        chk("slv_rd",       32'(slv_rd),       32'(e.rd));
        chk("slv_wdata",    32'(slv_wdata),    32'(e.d));
      end
    end
  end

  initial begin
    logic [N-1:0] g, prev, r;
    logic [N-1:0] obs[$];
    logic [N-1:0] rot_exp [5];

    rst_n     = 1'b0;
    mst_req   = '0;
    mst_addr  = 32'hDEADBEEF;
    mst_wr    = '1;
    mst_rd    = '1;
    mst_wdata = 32'hCAFEF00D;
    model_reset();
    #12;
    check_reset_outputs("init");
    @(negedge clk);
    rst_n = 1'b1;

    // Two requesters from reset; master 0 first, then direct handover to 2.
    cycle(4'b0101, 32'h44332211, 4'b0000, 4'b0101, 32'h88776655);
    @(posedge clk); #2;
    chk("first_grant", 32'(mst_grant), 32'h1);
    cycle(4'b0100, 32'h44332211, 4'b0000, 4'b0101, 32'h88776655);
    @(posedge clk); #2;
    chk("handover_grant", 32'(mst_grant), 32'h4);
    chk("handover_busy",  32'(busy),      32'h1);

    // Everyone requests; each owner drops for one cycle after 3 owned cycles.
    do_reset();
    prev = '0;
    for (int i = 0; i < 15; i++) begin
      r = '1;
      if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
      rand_cycle(r);
      @(posedge clk); #2;
      g = mst_grant;
      if (g != prev && g != '0) obs.push_back(g);
      prev = g;
    end
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rot_count", 32'(obs.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs.size(); i++) chk("rot_order", 32'(obs[i]), 32'(rot_exp[i]));

    // Merge: master 1 owns while master 2 drives all-ones.
    do_reset();
    cycle(4'b0010, 32'h00FF3C00, 4'b0110, 4'b0100, 32'h00FFA500);
    cycle(4'b0110, 32'h00FF3C00, 4'b0110, 4'b0100, 32'h00FFA500);
    cycle(4'b0110, 32'h00FF3C00, 4'b0110, 4'b0100, 32'h00FFA500);
    @(posedge clk); #2;
    chk("merge_addr",  32'(slv_addr),  32'h3C);
    chk("merge_wr",    32'(slv_wr),    32'h1);
    chk("merge_rd",    32'(slv_rd),    32'h0);
    chk("merge_wdata", 32'(slv_wdata), 32'hA5);

    // Idle bus with noisy master outputs.
    cycle(4'b0000, 32'h00FF3C00, 4'b0110, 4'b0100, 32'h00FFA500);
    for (int i = 0; i < 10; i++) begin
      rand_cycle(4'b0000);
      @(posedge clk); #2;
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_slv",  {14'h0, slv_addr, slv_wdata, slv_wr, slv_rd}, 32'h0);
    end

    // Watchdog: master 0 holds with master 3 waiting.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b1001, 32'h40302010, 4'b1001, 4'b0000, 32'h04030201);
    @(posedge clk); #2;
    chk("wdog_grant", 32'(mst_grant),    32'h8);
    chk("wdog_pulse", 32'(hold_timeout), 32'h1);
    cycle(4'b1001, 32'h40302010, 4'b1001, 4'b0000, 32'h04030201);
    @(posedge clk); #2;
    chk("wdog_pulse_end", 32'(hold_timeout), 32'h0);
    cycle(4'b0001, 32'h40302010, 4'b1001, 4'b0000, 32'h04030201);
    cycle(4'b0001, 32'h40302010, 4'b1001, 4'b0000, 32'h04030201);
    @(posedge clk); #2;
    chk("masked_no_grant", 32'(mst_grant), 32'h0);
    cycle(4'b0000, 32'h40302010, 4'b1001, 4'b0000, 32'h04030201);
    cycle(4'b0001, 32'h40302010, 4'b1001, 4'b0000, 32'h04030201);
    @(posedge clk); #2;
    chk("unmask_grant", 32'(mst_grant), 32'h1);

    // Reset while master 0 owns, then the first grant must go to master 0.
    do_reset();
    cycle(4'b1111, 32'h40302010, 4'b1111, 4'b0000, 32'h04030201);
    @(posedge clk); #2;
    chk("post_reset_grant", 32'(mst_grant), 32'h1);

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 500; i++) begin
      r = mst_req;
      for (int b = 0; b < N; b++) if ($urandom_range(3) == 0) r[b] = ~r[b];
      rand_cycle(r);
      if (i == 250) do_reset();
    end

    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
